// File: rtl/timestamp_rx.sv
// Reassembles the 59-bit timestamp from the LSB-first slow-readout byte stream.
// Define TIMESTAMP_RX_DELTA_EN to build the modular delta from the previous timestamp.
module timestamp_rx #(
  parameter  int dw  = 8,
  parameter  int len = 7,
  localparam int tw  = 3 + len * dw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [dw-1:0] byte_in,
  input  logic          byte_stb,
  input  logic          frame_start,
  output logic [tw-1:0] ts,
  output logic          ts_valid,
  output logic [tw-1:0] delta,
  output logic          delta_valid,
  output logic          frame_err
);

  localparam int cw = len * dw;
  localparam int bw = (len > 1) ? $clog2(len + 1) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e          state_q, state_d;
  logic [bw-1:0]   bcnt_q, bcnt_d;
  logic [2:0]      fast_q, fast_d;
  logic [cw-1:0]   count_q, count_d;
  logic [tw-1:0]   asm_q, asm_d;
  logic            asm_vld_q, asm_vld_d;
  logic [tw-1:0]   ts_q, ts_d;
  logic            ts_valid_q, ts_valid_d;
  logic            frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    fast_d      = fast_q;
    count_d     = count_q;
    asm_d       = asm_q;
    asm_vld_d   = 1'b0;
    frame_err_d = 1'b0;
    ts_d        = ts_q;
    ts_valid_d  = asm_vld_q;
    if (asm_vld_q) ts_d = asm_q;

    case (state_q)
      IDLE: begin
        if (byte_stb) begin
          if (frame_start) begin
            fast_d  = byte_in[dw-1 -: 3];
            bcnt_d  = '0;
            state_d = COLLECT;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (byte_stb) begin
          if (frame_start) begin
            frame_err_d = 1'b1;
            fast_d      = byte_in[dw-1 -: 3];
            bcnt_d      = '0;
          end else begin
            for (int unsigned i = 0; i < len; i++) begin
              if (bcnt_q == bw'(i)) count_d[i*dw +: dw] = byte_in;
            end
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == bw'(len - 1)) state_d = DONE;
          end
        end
      end
      DONE: begin
        // Snapshot the frame now so a back-to-back byte 0 landing this
        // cycle can overwrite fast_q without corrupting the published value.
        asm_d     = {count_q, fast_q};
        asm_vld_d = 1'b1;
        state_d   = IDLE;
        if (byte_stb) begin
          if (frame_start) begin
            fast_d  = byte_in[dw-1 -: 3];
            bcnt_d  = '0;
            state_d = COLLECT;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      fast_q      <= '0;
      count_q     <= '0;
      asm_q       <= '0;
      asm_vld_q   <= 1'b0;
      ts_q        <= '0;
      ts_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      fast_q      <= fast_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      asm_vld_q   <= asm_vld_d;
      ts_q        <= ts_d;
      ts_valid_q  <= ts_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ts        = ts_q;
  assign ts_valid  = ts_valid_q;
  assign frame_err = frame_err_q;

`ifdef TIMESTAMP_RX_DELTA_EN
  logic [tw-1:0] ts_prev_q, ts_prev_d;
  logic [tw-1:0] delta_q, delta_d;
  logic          delta_valid_q, delta_valid_d;
  logic          first_q, first_d;

  always_comb begin
    ts_prev_d     = ts_prev_q;
    delta_d       = delta_q;
    delta_valid_d = 1'b0;
    first_d       = first_q;
    if (ts_valid_q) begin
      ts_prev_d = ts_q;
      first_d   = 1'b0;
      if (!first_q) begin
        delta_d       = ts_q - ts_prev_q;
        delta_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_prev_q     <= '0;
      delta_q       <= '0;
      delta_valid_q <= 1'b0;
      first_q       <= 1'b1;
    end else begin
      ts_prev_q     <= ts_prev_d;
      delta_q       <= delta_d;
      delta_valid_q <= delta_valid_d;
      first_q       <= first_d;
    end
  end

  assign delta       = delta_q;
  assign delta_valid = delta_valid_q;
`else
  assign delta       = '0;
  assign delta_valid = 1'b0;
`endif

endmodule

// File: tb/tb_timestamp_rx.sv
// Directed self-checking bench for timestamp_rx; expectations follow TIMESTAMP_RX_DELTA_EN.
module tb_timestamp_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_stb;
  logic        frame_start;
  logic [58:0] ts;
  logic        ts_valid;
  logic [58:0] delta;
  logic        delta_valid;
  logic        frame_err;

  int vecs = 0;
  int errs = 0;
  logic [58:0] pub_q[$];

`ifdef TIMESTAMP_RX_DELTA_EN
  localparam bit DV_ON = 1'b1;
`else
  localparam bit DV_ON = 1'b0;
`endif

  localparam logic [58:0] TS_A    = 59'h815;
  localparam logic [58:0] TS_B    = 59'h819;
  localparam logic [58:0] TS_ONES = 59'h7FF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  timestamp_rx #(.dw(8), .len(7)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_stb(byte_stb), .frame_start(frame_start),
    .ts(ts), .ts_valid(ts_valid), .delta(delta), .delta_valid(delta_valid), .frame_err(frame_err)
  );

  always @(negedge clk) if (ts_valid) pub_q.push_back(ts);

  task automatic put(input logic [7:0] b, input logic s);
    byte_in = b; byte_stb = 1'b1; frame_start = s;
    @(posedge clk); #1;
    byte_stb = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [63:0] v, input int gap);
    for (int k = 0; k < 8; k++) begin
      put(v[8*k +: 8], k == 0);
      if (k < 7) idle(gap);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; byte_stb = 1'b0; frame_start = 1'b0; byte_in = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(1);
    vecs++; if (ts !== 59'd0) begin errs++; $display("FAIL reset_ts got %h exp 0", ts); end
    vecs++; if (delta !== 59'd0) begin errs++; $display("FAIL reset_delta got %h exp 0", delta); end
    vecs++; if (ts_valid !== 1'b0) begin errs++; $display("FAIL reset_ts_valid got %b exp 0", ts_valid); end
    vecs++; if (delta_valid !== 1'b0) begin errs++; $display("FAIL reset_delta_valid got %b exp 0", delta_valid); end
    vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
  endtask

  task automatic test_basic;
    send_frame(64'h00000000_000102A0, 0);
    idle(1);
    vecs++; if (ts_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid got %b exp 0", ts_valid); end
    idle(1);
    vecs++; if (ts_valid !== 1'b1) begin errs++; $display("FAIL basic_ts_valid got %b exp 1", ts_valid); end
    vecs++; if (ts !== TS_A) begin errs++; $display("FAIL basic_ts got %h exp %h", ts, TS_A); end
    idle(1);
    vecs++; if (ts_valid !== 1'b0) begin errs++; $display("FAIL basic_pulse_width got %b exp 0", ts_valid); end
    vecs++; if (delta_valid !== 1'b0) begin errs++; $display("FAIL basic_first_dv got %b exp 0", delta_valid); end
    vecs++; if (delta !== 59'd0) begin errs++; $display("FAIL basic_first_delta got %h exp 0", delta); end
    vecs++; if (ts !== TS_A) begin errs++; $display("FAIL basic_ts_hold got %h exp %h", ts, TS_A); end
  endtask

  task automatic test_delta_gaps;
    for (int gap = 0; gap <= 5; gap++) begin
      send_frame(64'h00000000_000102A0, gap);
      idle(4);
      send_frame(64'h00000000_00010320, gap);
      idle(2);
      vecs++; if (ts !== TS_B) begin errs++; $display("FAIL delta_ts gap=%0d got %h exp %h", gap, ts, TS_B); end
      idle(1);
      vecs++; if (delta_valid !== DV_ON) begin errs++; $display("FAIL delta_dv gap=%0d got %b exp %b", gap, delta_valid, DV_ON); end
      vecs++; if (delta !== (DV_ON ? 59'd4 : 59'd0)) begin errs++; $display("FAIL delta_val gap=%0d got %h", gap, delta); end
      idle(1);
      vecs++; if (delta_valid !== 1'b0) begin errs++; $display("FAIL delta_dv_width gap=%0d got %b exp 0", gap, delta_valid); end
    end
  endtask

  task automatic test_wrap;
    send_frame(64'hFFFFFFFF_FFFFFFE0, 1);
    idle(4);
    vecs++; if (ts !== TS_ONES) begin errs++; $display("FAIL wrap_max_ts got %h exp %h", ts, TS_ONES); end
    send_frame(64'h00000000_00000060, 0);
    idle(2);
    vecs++; if (ts !== 59'd3) begin errs++; $display("FAIL wrap_ts got %h exp 3", ts); end
    idle(1);
    vecs++; if (delta_valid !== DV_ON) begin errs++; $display("FAIL wrap_dv got %b exp %b", delta_valid, DV_ON); end
    vecs++; if (delta !== (DV_ON ? 59'd4 : 59'd0)) begin errs++; $display("FAIL wrap_delta got %h", delta); end
  endtask

  task automatic test_restart;
    put(8'hA0, 1'b1); put(8'h02, 1'b0); put(8'h01, 1'b0); put(8'h00, 1'b0);
    vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL restart_no_err got %b exp 0", frame_err); end
    put(8'h20, 1'b1);
    vecs++; if (frame_err !== 1'b1) begin errs++; $display("FAIL restart_err got %b exp 1", frame_err); end
    put(8'h03, 1'b0);
    vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL restart_err_width got %b exp 0", frame_err); end
    put(8'h01, 1'b0);
    for (int k = 0; k < 5; k++) put(8'h00, 1'b0);
    idle(2);
    vecs++; if (ts_valid !== 1'b1) begin errs++; $display("FAIL restart_ts_valid got %b exp 1", ts_valid); end
    vecs++; if (ts !== TS_B) begin errs++; $display("FAIL restart_ts got %h exp %h", ts, TS_B); end
    idle(1);
    vecs++; if (delta !== (DV_ON ? 59'h816 : 59'd0)) begin errs++; $display("FAIL restart_delta got %h", delta); end
    idle(2);
    pub_q.delete();
    put(8'h55, 1'b0);
    vecs++; if (frame_err !== 1'b1) begin errs++; $display("FAIL stray_err got %b exp 1", frame_err); end
    idle(5);
    vecs++; if (ts !== TS_B) begin errs++; $display("FAIL stray_ts got %h exp %h", ts, TS_B); end
    vecs++; if (pub_q.size() !== 0) begin errs++; $display("FAIL stray_pub got %0d exp 0", pub_q.size()); end
  endtask

  task automatic test_back_to_back;
    idle(2);
    pub_q.delete();
    send_frame(64'h00000000_000102A0, 0);
    send_frame(64'h00000000_00010320, 0);
    idle(2);
    vecs++; if (ts !== TS_B) begin errs++; $display("FAIL b2b_ts got %h exp %h", ts, TS_B); end
    idle(1);
    vecs++; if (delta !== (DV_ON ? 59'd4 : 59'd0)) begin errs++; $display("FAIL b2b_delta got %h", delta); end
    vecs++; if (pub_q.size() !== 2) begin errs++; $display("FAIL b2b_pub_count got %0d exp 2", pub_q.size()); end
    if (pub_q.size() > 0) begin
      vecs++; if (pub_q[0] !== TS_A) begin errs++; $display("FAIL b2b_first_ts got %h exp %h", pub_q[0], TS_A); end
    end
  endtask

  task automatic test_reset_mid;
    put(8'hA0, 1'b1); put(8'h02, 1'b0); put(8'h01, 1'b0); put(8'h00, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    vecs++; if (ts !== 59'd0) begin errs++; $display("FAIL rmid_ts got %h exp 0", ts); end
    vecs++; if (delta !== 59'd0) begin errs++; $display("FAIL rmid_delta got %h exp 0", delta); end
    vecs++; if ({ts_valid, delta_valid, frame_err} !== 3'b000) begin errs++; $display("FAIL rmid_flags got %b exp 000", {ts_valid, delta_valid, frame_err}); end
    send_frame(64'h00000000_00010320, 0);
    idle(2);
    vecs++; if (ts !== TS_B) begin errs++; $display("FAIL rmid_next_ts got %h exp %h", ts, TS_B); end
    idle(1);
    vecs++; if (delta_valid !== 1'b0) begin errs++; $display("FAIL rmid_first_dv got %b exp 0", delta_valid); end
    vecs++; if (delta !== 59'd0) begin errs++; $display("FAIL rmid_first_delta got %h exp 0", delta); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_delta_gaps;
    test_wrap;
    test_restart;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
